// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one external memory port between the instruction
// miss path (I) and the data-side path (D). One transfer is in flight at a time,
// ties are broken round-robin, and a watchdog forces completion of a hung transfer.
module mem_bus_arbiter #(
  parameter int unsigned A_WIDTH = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               clrn,
  input  logic [A_WIDTH-1:0] i_a,
  input  logic               i_strobe,
  output logic [31:0]        i_dout,
  output logic               i_ready,
  input  logic [A_WIDTH-1:0] d_a,
  input  logic               d_strobe,
  input  logic               d_we,
  input  logic [3:0]         d_sel,
  input  logic [31:0]        d_wdata,
  output logic [31:0]        d_rdata,
  output logic               d_ready,
  output logic [A_WIDTH-1:0] m_a,
  output logic               m_strobe,
  output logic               m_we,
  output logic [3:0]         m_sel,
  output logic [31:0]        m_wdata,
  input  logic [31:0]        m_rdata,
  input  logic               m_ready,
  output logic               grant_i,
  output logic               grant_d,
  output logic               bus_err
);

  localparam int unsigned CNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned CNT_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_XFER = 2'd1,
    D_XFER = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_last_d;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_bus_err;
  logic [A_WIDTH-1:0] r_a;
  logic               r_we;
  logic [3:0]         r_sel;
  logic [31:0]        r_wdata;

  logic               w_load;
  logic               w_load_d;
  logic               w_timeout;
  logic               w_done;

  // State register; async reset drops the bus strobe without waiting for an edge
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Arbitration, completion and watchdog decode
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_d    = 1'b0;
    w_timeout   = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_strobe || d_strobe) begin
          w_load      = 1'b1;
          // D wins alone, or on a tie when I was granted last
          w_load_d    = d_strobe && (!i_strobe || !r_last_d);
          w_state_nxt = w_load_d ? D_XFER : I_XFER;
        end
      end
      I_XFER, D_XFER: begin
        // A real m_ready always takes precedence over the watchdog
        w_timeout = (TIMEOUT != 0) && !m_ready && (r_cnt == CNT_W'(CNT_LAST));
        w_done    = m_ready || w_timeout;
        if (w_done) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Request latch: values captured at grant stay stable for the whole transfer
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_a     <= '0;
      r_we    <= 1'b0;
      r_sel   <= 4'h0;
      r_wdata <= 32'h0;
    end else if (w_load) begin
      r_a     <= w_load_d ? d_a : i_a;
      r_we    <= w_load_d && d_we;
      r_sel   <= w_load_d ? d_sel : 4'hF;
      r_wdata <= w_load_d ? d_wdata : 32'h0;
    end
  end

  // Watchdog counter: cleared at grant, counts transfer cycles without m_ready
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)                           r_cnt <= '0;
    else if (w_load)                     r_cnt <= '0;
    else if (r_state != IDLE && !m_ready) r_cnt <= r_cnt + CNT_W'(1);
  end

  // Round-robin history and sticky timeout flag
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_last_d  <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      if (w_done)    r_last_d  <= (r_state == D_XFER);
      if (w_timeout) r_bus_err <= 1'b1;
    end
  end

  assign grant_i  = (r_state == I_XFER);
  assign grant_d  = (r_state == D_XFER);
  assign m_strobe = grant_i || grant_d;
  assign m_a      = r_a;
  assign m_we     = r_we;
  assign m_sel    = r_sel;
  assign m_wdata  = r_wdata;
  assign bus_err  = r_bus_err;

  // Completion is returned only to an owner still holding its strobe
  assign i_ready  = grant_i && i_strobe && w_done;
  assign d_ready  = grant_d && d_strobe && w_done;
  assign i_dout   = (grant_i && !w_timeout) ? m_rdata : 32'h0;
  assign d_rdata  = (grant_d && !w_timeout) ? m_rdata : 32'h0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: expected transfers are queued when requests are
// driven and checked against the bus and completion signals as they are served.
module tb_mem_bus_arbiter;

  localparam int unsigned AW  = 32;
  localparam int unsigned TMO = 8;

  logic          clk = 1'b0;
  logic          clrn;
  logic [AW-1:0] i_a;
  logic          i_strobe;
  logic [31:0]   i_dout;
  logic          i_ready;
  logic [AW-1:0] d_a;
  logic          d_strobe;
  logic          d_we;
  logic [3:0]    d_sel;
  logic [31:0]   d_wdata;
  logic [31:0]   d_rdata;
  logic          d_ready;
  logic [AW-1:0] m_a;
  logic          m_strobe;
  logic          m_we;
  logic [3:0]    m_sel;
  logic [31:0]   m_wdata;
  logic [31:0]   m_rdata;
  logic          m_ready;
  logic          grant_i;
  logic          grant_d;
  logic          bus_err;

  mem_bus_arbiter #(.A_WIDTH(AW), .TIMEOUT(TMO)) u_dut (
    .clk(clk), .clrn(clrn),
    .i_a(i_a), .i_strobe(i_strobe), .i_dout(i_dout), .i_ready(i_ready),
    .d_a(d_a), .d_strobe(d_strobe), .d_we(d_we), .d_sel(d_sel),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ready(d_ready),
    .m_a(m_a), .m_strobe(m_strobe), .m_we(m_we), .m_sel(m_sel),
    .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ready(m_ready),
    .grant_i(grant_i), .grant_d(grant_d), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;

  typedef struct {
    logic        is_d;
    logic [31:0] a;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          wait_c;  // m_ready in strobe cycle wait_c+1; negative = never
    logic        drop;    // owner withdraws its strobe in the first cycle
  } exp_t;

  exp_t sb[$];

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_i(input logic [31:0] a, input logic [31:0] rd, input int w, input logic drop);
    exp_t e;
    e.is_d = 1'b0; e.a = a; e.we = 1'b0; e.sel = 4'hF; e.wdata = 32'h0;
    e.rdata = rd; e.wait_c = w; e.drop = drop;
    sb.push_back(e);
  endtask

  task automatic push_d(input logic [31:0] a, input logic we, input logic [3:0] sel,
                        input logic [31:0] wd, input logic [31:0] rd, input int w);
    exp_t e;
    e.is_d = 1'b1; e.a = a; e.we = we; e.sel = sel; e.wdata = wd;
    e.rdata = rd; e.wait_c = w; e.drop = 1'b0;
    sb.push_back(e);
  endtask

  task automatic drive_i(input logic [31:0] a);
    i_a = a; i_strobe = 1'b1;
  endtask

  task automatic drive_d(input logic [31:0] a, input logic we, input logic [3:0] sel,
                         input logic [31:0] wd);
    d_a = a; d_we = we; d_sel = sel; d_wdata = wd; d_strobe = 1'b1;
  endtask

  // Wait for a bus transfer, play the memory side and compare with the queue head
  task automatic serve(output int lat);
    exp_t        e;
    int          n;
    logic [31:0] dx;
    n = 0;
    while (m_strobe !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    lat = n;
    if (m_strobe !== 1'b1) begin
      check_eq("strobe_wait", 128'(m_strobe), 128'(1));
      return;
    end
    if (sb.size() == 0) begin
      check_eq("sb_underflow", 128'(sb.size()), 128'(1));
      return;
    end
    e = sb.pop_front();
    if (e.wait_c < 0) begin
      m_rdata = 32'hA5A5_A5A5;
      for (int c = 1; c <= int'(TMO); c++) begin
        check_eq("tmo_hold", {m_strobe, grant_i, grant_d, m_a, m_we, m_sel, m_wdata},
                 {1'b1, !e.is_d, e.is_d, e.a, e.we, e.sel, e.wdata});
        if (c == int'(TMO)) begin
          check_eq("tmo_ready", {i_ready, d_ready}, {!e.is_d, e.is_d});
          check_eq("tmo_data", {i_dout, d_rdata}, 64'h0);
        end else begin
          check_eq("tmo_noready", {i_ready, d_ready}, 2'b00);
          @(negedge clk);
        end
      end
    end else begin
      if (e.drop) begin
        if (e.is_d) d_strobe = 1'b0; else i_strobe = 1'b0;
        #1;
      end
      for (int c = 1; c <= e.wait_c; c++) begin
        check_eq("bus_hold", {m_strobe, grant_i, grant_d, m_a, m_we, m_sel, m_wdata},
                 {1'b1, !e.is_d, e.is_d, e.a, e.we, e.sel, e.wdata});
        check_eq("wait_noready", {i_ready, d_ready}, 2'b00);
        @(negedge clk);
      end
      m_rdata = e.rdata;
      m_ready = 1'b1;
      #1;
      check_eq("bus_done", {m_strobe, grant_i, grant_d, m_a, m_we, m_sel, m_wdata},
               {1'b1, !e.is_d, e.is_d, e.a, e.we, e.sel, e.wdata});
      check_eq("ready", {i_ready, d_ready},
               {!e.is_d && !e.drop, e.is_d && !e.drop});
      dx = e.rdata;
      check_eq("rdata", {i_dout, d_rdata}, e.is_d ? {32'h0, dx} : {dx, 32'h0});
    end
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    m_rdata = 32'h0;
    if (e.is_d) d_strobe = 1'b0; else i_strobe = 1'b0;
    @(negedge clk);
    check_eq("idle_gap", {m_strobe, i_ready, d_ready}, 3'b000);
    if (e.wait_c < 0) check_eq("tmo_err", 128'(bus_err), 128'(1));
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench time limit exceeded");
  end

  initial begin
    int lat;
    clrn = 1'b0; i_a = '0; i_strobe = 1'b0; d_a = '0; d_strobe = 1'b0;
    d_we = 1'b0; d_sel = 4'h0; d_wdata = 32'h0; m_rdata = 32'h0; m_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("reset_out", {m_strobe, m_we, grant_i, grant_d, i_ready, d_ready, bus_err,
                           m_a, m_sel, m_wdata}, 128'h0);
    clrn = 1'b1;
    @(posedge clk); #1;

    // Stray m_ready while idle is ignored
    m_ready = 1'b1; m_rdata = 32'h1234_5678;
    #1;
    check_eq("idle_mready", {i_ready, d_ready, i_dout, d_rdata}, 66'h0);
    @(posedge clk); #1;
    m_ready = 1'b0; m_rdata = 32'h0;
    @(negedge clk);
    check_eq("idle_mready_st", {m_strobe, bus_err}, 2'b00);

    // First tie after reset: D then I, one idle cycle between
    @(posedge clk); #1;
    push_d(32'h8000_0010, 1'b0, 4'hF, 32'h0, 32'h1111_1111, 1);
    push_i(32'h0040_0000, 32'h2222_2222, 2, 1'b0);
    drive_d(32'h8000_0010, 1'b0, 4'hF, 32'h0);
    drive_i(32'h0040_0000);
    serve(lat); check_eq("tie1_lat", 128'(lat), 128'(2));
    serve(lat); check_eq("tie1_gap", 128'(lat), 128'(1));

    // I read
    @(posedge clk); #1;
    push_i(32'hBFC0_0000, 32'h3C1D_BFC0, 3, 1'b0);
    drive_i(32'hBFC0_0000);
    serve(lat); check_eq("iread_lat", 128'(lat), 128'(2));

    // D write with 4 wait cycles
    @(posedge clk); #1;
    push_d(32'h8000_1004, 1'b1, 4'b0011, 32'hDEAD_BEEF, 32'h0BAD_F00D, 4);
    drive_d(32'h8000_1004, 1'b1, 4'b0011, 32'hDEAD_BEEF);
    serve(lat); check_eq("dwrite_lat", 128'(lat), 128'(2));

    // Tie after a D grant: I first
    @(posedge clk); #1;
    push_i(32'h0040_0100, 32'h3333_3333, 0, 1'b0);
    push_d(32'h8000_0020, 1'b0, 4'hF, 32'h0, 32'h4444_4444, 2);
    drive_i(32'h0040_0100);
    drive_d(32'h8000_0020, 1'b0, 4'hF, 32'h0);
    serve(lat); check_eq("tie2_lat", 128'(lat), 128'(2));
    serve(lat); check_eq("tie2_gap", 128'(lat), 128'(1));

    // Flush: I withdraws after grant, pending D follows
    @(posedge clk); #1;
    push_i(32'h0040_0200, 32'h5555_5555, 2, 1'b1);
    drive_i(32'h0040_0200);
    @(posedge clk); #1;
    push_d(32'h8000_0030, 1'b0, 4'hF, 32'h0, 32'h6666_6666, 1);
    drive_d(32'h8000_0030, 1'b0, 4'hF, 32'h0);
    serve(lat);
    serve(lat); check_eq("flush_next", 128'(lat), 128'(1));

    // Watchdog: D read never answered
    @(posedge clk); #1;
    push_d(32'h8000_2000, 1'b0, 4'hF, 32'h0, 32'h0, -1);
    drive_d(32'h8000_2000, 1'b0, 4'hF, 32'h0);
    serve(lat);

    // Error flag persists across a good transfer
    @(posedge clk); #1;
    push_i(32'hBFC0_0004, 32'h0000_0001, 1, 1'b0);
    drive_i(32'hBFC0_0004);
    serve(lat);
    check_eq("err_sticky", 128'(bus_err), 128'(1));

    // Reset mid-transfer drops the bus asynchronously
    @(posedge clk); #1;
    drive_i(32'hBFC0_0008);
    @(negedge clk);
    @(negedge clk);
    check_eq("pre_rst", {m_strobe, grant_i}, 2'b11);
    @(posedge clk); #3;
    clrn = 1'b0;
    #1;
    check_eq("rst_async", {m_strobe, grant_i, bus_err}, 3'b000);
    @(negedge clk);
    clrn = 1'b1;
    check_eq("rst_release", 128'(m_strobe), 128'(0));
    push_i(32'hBFC0_0008, 32'h7777_7777, 0, 1'b0);
    serve(lat); check_eq("rst_lat", 128'(lat), 128'(1));

    // m_ready in the watchdog's final cycle is a normal completion
    @(posedge clk); #1;
    push_d(32'h8000_3000, 1'b0, 4'hF, 32'h0, 32'hCAFE_F00D, int'(TMO) - 1);
    drive_d(32'h8000_3000, 1'b0, 4'hF, 32'h0);
    serve(lat);
    check_eq("same_cycle_err", 128'(bus_err), 128'(0));

    check_eq("sb_drain", 128'(sb.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
